mem_wb_writeback: RTL

Write-back end of the pipelined MIPS datapath: captures the MEM-stage outputs (ALU result, data-memory read data, destination register, WB control bits) into the MEM/WB pipeline register and selects the write-back value. It commits that value into the 32×32 register file and serves the decode stage's two combinational read ports, with same-cycle write bypass. It also drives the write-back half of the forwarding bus and a retired-write counter.

---
 rtl/mem_wb_writeback.sv | 111 +++++++++++
 1 files changed

// File: rtl/mem_wb_writeback.sv
// MEM/WB pipeline register, write-back select, 32-entry register file with
// write-through read bypass, forwarding outputs and a retired-write counter.
module mem_wb_writeback #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              RegWrite,
  input  logic              MemtoReg,
  input  logic [DATA_W-1:0] aluresult,
  input  logic [DATA_W-1:0] memdata,
  input  logic [ADDR_W-1:0] rd,
  input  logic              valid,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic              wb_regwrite,
  output logic [ADDR_W-1:0] wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic [CNT_W-1:0]  retired
);

  localparam int NREG = 1 << ADDR_W;

  logic              v_q, v_d;
  logic              rw_q, rw_d;
  logic              m2r_q, m2r_d;
  logic [DATA_W-1:0] alu_q, alu_d;
  logic [DATA_W-1:0] mem_q, mem_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic [CNT_W-1:0]  retired_q, retired_d;

  logic              we;
  logic [DATA_W-1:0] wb_val;

  // MEM/WB capture: flush beats stall beats load
  always_comb begin
    v_d   = v_q;
    rw_d  = rw_q;
    m2r_d = m2r_q;
    alu_d = alu_q;
    mem_d = mem_q;
    rd_d  = rd_q;
    if (flush) begin
      v_d   = 1'b0;
      rw_d  = 1'b0;
      m2r_d = 1'b0;
      alu_d = '0;
      mem_d = '0;
      rd_d  = '0;
    end else if (!stall) begin
      v_d   = valid;
      rw_d  = RegWrite;
      m2r_d = MemtoReg;
      alu_d = aluresult;
      mem_d = memdata;
      rd_d  = rd;
    end
  end

  assign wb_val = m2r_q ? mem_q : alu_q;
  // A stalled instruction neither commits nor forwards; it commits once on release.
  assign we     = v_q & rw_q & (rd_q != '0) & ~stall;

  always_comb begin
    regs_d = regs_q;
    if (we) regs_d[rd_q] = wb_val;
  end

  assign retired_d = retired_q + {{(CNT_W-1){1'b0}}, we};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q       <= 1'b0;
      rw_q      <= 1'b0;
      m2r_q     <= 1'b0;
      alu_q     <= '0;
      mem_q     <= '0;
      rd_q      <= '0;
      retired_q <= '0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      v_q       <= v_d;
      rw_q      <= rw_d;
      m2r_q     <= m2r_d;
      alu_q     <= alu_d;
      mem_q     <= mem_d;
      rd_q      <= rd_d;
      retired_q <= retired_d;
      regs_q    <= regs_d;
    end
  end

  assign rs_data = (rs_addr == '0) ? '0 :
                   (we && rs_addr == rd_q) ? wb_val : regs_q[rs_addr];
  assign rt_data = (rt_addr == '0) ? '0 :
                   (we && rt_addr == rd_q) ? wb_val : regs_q[rt_addr];

  assign wb_regwrite = we;
  assign wb_rd       = rd_q;
  assign wb_data     = wb_val;
  assign retired     = retired_q;

endmodule
